multi_timer: RTL and testbench

- Multi-channel programmable interval timer; successor to the single down-counter interrupt timer.
- Provides NUM_TIMERS independent channels, each with:
  - one-shot or periodic mode,
  - auto-reload,
  - per-channel interrupt enable,
  - sticky write-1-to-clear pending status.
- Also provides a shared clock prescaler and full register read-back.
- Sits on the IO bus as a slave; its interrupt vector feeds the interrupt controller.

---
 rtl/multi_timer_if.sv | 28 ++
 rtl/multi_timer.sv | 184 ++++++++++++++++++
 tb/tb_multi_timer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/multi_timer_if.sv
// IO bus connection shared by bus masters and register-mapped slaves.
//   write_en, read_en : single-cycle access strobes from the master
//   address           : byte address of the access
//   write_data        : store data from the master
//   read_data         : load data returned by the selected slave
interface io_bus_interface;
  logic        write_en;
  logic        read_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (
    output write_en,
    output read_en,
    output address,
    output write_data,
    input  read_data
  );

  modport slave (
    input  write_en,
    input  read_en,
    input  address,
    input  write_data,
    output read_data
  );
endinterface

// File: rtl/multi_timer.sv
// Multi-channel programmable interval timer with a shared prescaler.
// Each channel counts down on prescaler ticks. On expiry it either reloads
// (periodic mode) or stops and disables itself (one-shot mode), and it sets
// a sticky pending flag that is cleared by writing 1.
//   clk             : system clock
//   reset           : synchronous, active-high reset
//   io_bus          : register access slave; read_data is registered
//   timer_interrupt : per-channel level interrupt, pending & irq_en
module multi_timer #(
  parameter logic [31:0] BASE_ADDRESS   = 32'h0000_0000,
  parameter int unsigned NUM_TIMERS     = 4,
  parameter int unsigned COUNTER_WIDTH  = 32,
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  io_bus_interface.slave        io_bus,
  output logic [NUM_TIMERS-1:0] timer_interrupt
);

  localparam int unsigned CW         = COUNTER_WIDTH;
  localparam int unsigned PW         = PRESCALE_WIDTH;
  localparam int unsigned GLOBAL_OFS = 16 * NUM_TIMERS;

  // Architectural state
  logic [CW-1:0]         count      [NUM_TIMERS];
  logic [CW-1:0]         reload     [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] enable;
  logic [NUM_TIMERS-1:0] periodic;
  logic [NUM_TIMERS-1:0] irq_en;
  logic [NUM_TIMERS-1:0] pending;
  logic [PW-1:0]         prescale;
  logic [PW-1:0]         pre_cnt;

  // Next-state values
  logic [CW-1:0]         count_nxt  [NUM_TIMERS];
  logic [CW-1:0]         reload_nxt [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] enable_nxt;
  logic [NUM_TIMERS-1:0] periodic_nxt;
  logic [NUM_TIMERS-1:0] irq_en_nxt;
  logic [NUM_TIMERS-1:0] pending_nxt;
  logic [PW-1:0]         prescale_nxt;
  logic [PW-1:0]         pre_cnt_nxt;

  // Decode and datapath helpers
  logic [31:0]           offset_c;
  logic [3:0]            chan_sel_c;
  logic [1:0]            reg_sel_c;
  logic                  is_chan_c;
  logic                  is_prescale_c;
  logic                  is_summary_c;
  logic                  wr_prescale_c;
  logic [NUM_TIMERS-1:0] wr_count_c;
  logic [NUM_TIMERS-1:0] wr_ctrl_c;
  logic [NUM_TIMERS-1:0] wr_status_c;
  logic [NUM_TIMERS-1:0] active_c;
  logic [NUM_TIMERS-1:0] expire_c;
  logic                  tick_c;
  logic [31:0]           rdata_c;

  // Address decode relative to the block base; unaligned offsets are unmapped
  always_comb begin
    offset_c      = io_bus.address - BASE_ADDRESS;
    chan_sel_c    = offset_c[7:4];
    reg_sel_c     = offset_c[3:2];
    is_chan_c     = (offset_c < 32'(GLOBAL_OFS)) && (offset_c[1:0] == 2'b00);
    is_prescale_c = (offset_c == 32'(GLOBAL_OFS));
    is_summary_c  = (offset_c == 32'(GLOBAL_OFS + 4));
    wr_prescale_c = io_bus.write_en && is_prescale_c;
  end

  // Per-channel write strobes
  always_comb begin
    wr_count_c  = '0;
    wr_ctrl_c   = '0;
    wr_status_c = '0;
    for (int n = 0; n < NUM_TIMERS; n++) begin
      if (io_bus.write_en && is_chan_c && (chan_sel_c == 4'(n))) begin
        wr_count_c[n]  = (reg_sel_c == 2'd0);
        wr_ctrl_c[n]   = (reg_sel_c == 2'd1);
        wr_status_c[n] = (reg_sel_c == 2'd2);
      end
    end
  end

  // Shared prescaler: tick once every prescale+1 cycles, restart on write
  always_comb begin
    tick_c       = (pre_cnt == prescale);
    prescale_nxt = prescale;
    pre_cnt_nxt  = tick_c ? '0 : pre_cnt + PW'(1);
    if (wr_prescale_c) begin
      prescale_nxt = io_bus.write_data[PW-1:0];
      pre_cnt_nxt  = '0;
    end
  end

  // Channel next state; bus writes are applied last so they take priority,
  // except that an expiry keeps pending set over a simultaneous W1C
  always_comb begin
    count_nxt    = count;
    reload_nxt   = reload;
    enable_nxt   = enable;
    periodic_nxt = periodic;
    irq_en_nxt   = irq_en;
    pending_nxt  = pending;
    active_c     = '0;
    expire_c     = '0;
    for (int n = 0; n < NUM_TIMERS; n++) begin
      active_c[n] = tick_c && enable[n] && (count[n] != '0);
      expire_c[n] = active_c[n] && (count[n] == CW'(1));
      if (active_c[n]) begin
        if (!expire_c[n])    count_nxt[n] = count[n] - CW'(1);
        else if (periodic[n]) count_nxt[n] = reload[n];
        else                 count_nxt[n] = '0;
      end
      if (wr_status_c[n] && io_bus.write_data[0]) pending_nxt[n] = 1'b0;
      // A COUNT write cancels the coinciding expiry entirely
      if (expire_c[n] && !wr_count_c[n]) begin
        pending_nxt[n] = 1'b1;
        if (!periodic[n]) enable_nxt[n] = 1'b0;
      end
      if (wr_ctrl_c[n]) begin
        enable_nxt[n]   = io_bus.write_data[0];
        periodic_nxt[n] = io_bus.write_data[1];
        irq_en_nxt[n]   = io_bus.write_data[2];
      end
      if (wr_count_c[n]) begin
        count_nxt[n]  = io_bus.write_data[CW-1:0];
        reload_nxt[n] = io_bus.write_data[CW-1:0];
      end
    end
  end

  // Read-back mux; unmapped addresses return zero
  always_comb begin
    rdata_c = '0;
    if (is_chan_c) begin
      for (int n = 0; n < NUM_TIMERS; n++) begin
        if (chan_sel_c == 4'(n)) begin
          case (reg_sel_c)
            2'd0:    rdata_c = 32'(count[n]);
            2'd1:    rdata_c = {29'b0, irq_en[n], periodic[n], enable[n]};
            2'd2:    rdata_c = {31'b0, pending[n]};
            default: rdata_c = '0;
          endcase
        end
      end
    end else if (is_prescale_c) begin
      rdata_c = 32'(prescale);
    end else if (is_summary_c) begin
      rdata_c = 32'(pending);
    end
  end

  // State registers; the interrupt is registered from next-state flops only
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NUM_TIMERS; n++) begin
        count[n]  <= '0;
        reload[n] <= '0;
      end
      enable           <= '0;
      periodic         <= '0;
      irq_en           <= '0;
      pending          <= '0;
      prescale         <= '0;
      pre_cnt          <= '0;
      io_bus.read_data <= '0;
      timer_interrupt  <= '0;
    end else begin
      count           <= count_nxt;
      reload          <= reload_nxt;
      enable          <= enable_nxt;
      periodic        <= periodic_nxt;
      irq_en          <= irq_en_nxt;
      pending         <= pending_nxt;
      prescale        <= prescale_nxt;
      pre_cnt         <= pre_cnt_nxt;
      if (io_bus.read_en) io_bus.read_data <= rdata_c;
      timer_interrupt <= pending_nxt & irq_en_nxt;
    end
  end

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: 4 channels, 8-bit counters, base 0x100.
module tb_multi_timer;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [31:0] PRESCALE_A = BASE + 32'd64;
  localparam logic [31:0] SUMMARY_A  = BASE + 32'd68;
  localparam logic [31:0] UNMAP_A    = BASE + 32'd72;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] timer_interrupt;
  int         tests = 0;
  int         failed = 0;

  io_bus_interface bus();

  multi_timer #(
    .BASE_ADDRESS  (BASE),
    .NUM_TIMERS    (4),
    .COUNTER_WIDTH (8),
    .PRESCALE_WIDTH(16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .io_bus         (bus),
    .timer_interrupt(timer_interrupt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ra(input int ch, input int r);
    return BASE + 32'(16 * ch) + 32'(4 * r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      failed++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.write_en   = 1'b1;
    bus.address    = a;
    bus.write_data = d;
    cyc();
    bus.write_en = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [31:0] a, input logic [31:0] want);
    bus.read_en = 1'b1;
    bus.address = a;
    cyc();
    bus.read_en = 1'b0;
    chk(tag, bus.read_data, want);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          k;
    logic [31:0] want;
    logic [31:0] held;
    logic        any_irq;

    bus.write_en   = 1'b0;
    bus.read_en    = 1'b0;
    bus.address    = '0;
    bus.write_data = '0;
    reset          = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;

    // Reset state
    chk("rst_irq", 32'(timer_interrupt), 32'h0);
    chk("rst_rdata", bus.read_data, 32'h0);
    rdchk("rst_count0", ra(0, 0), 32'h0);
    rdchk("rst_prescale", PRESCALE_A, 32'h0);

    // One-shot on ch0 with PRESCALE=0
    wr(ra(0, 0), 32'd5);
    wr(ra(0, 1), 32'h5);
    cyc();
    for (int i = 0; i < 5; i++) begin
      rdchk("os_count", ra(0, 0), 32'(4 - i));
      chk("os_irq", 32'(timer_interrupt[0]), (i >= 3) ? 32'h1 : 32'h0);
    end
    rdchk("os_ctrl", ra(0, 1), 32'h4);
    rdchk("os_status", ra(0, 2), 32'h1);
    held = bus.read_data;
    cyc();
    chk("rdata_hold", bus.read_data, held);
    rdchk("os_count_stays0", ra(0, 0), 32'h0);
    wr(ra(0, 2), 32'h1);
    chk("os_w1c_irq", 32'(timer_interrupt[0]), 32'h0);
    rdchk("os_status_clr", ra(0, 2), 32'h0);

    // Periodic on ch1 with PRESCALE=2: expiry every 12 cycles
    wr(PRESCALE_A, 32'd2);
    wr(ra(1, 0), 32'd4);
    wr(ra(1, 1), 32'h7);
    for (int c = 3; c <= 24; c++) begin
      if (c == 13) begin
        bus.write_en   = 1'b1;
        bus.address    = ra(1, 2);
        bus.write_data = 32'h1;
      end else begin
        bus.read_en = 1'b1;
        bus.address = ra(1, 0);
      end
      cyc();
      bus.write_en = 1'b0;
      bus.read_en  = 1'b0;
      if (c != 13) begin
        k    = ((c - 1) / 3) % 4;
        want = (k == 0) ? 32'd4 : 32'(4 - k);
        chk("per_count", bus.read_data, want);
      end
      chk("per_irq", 32'(timer_interrupt[1]), (c == 12 || c >= 24) ? 32'h1 : 32'h0);
    end
    wr(ra(1, 1), 32'h0);
    wr(ra(1, 2), 32'h1);
    chk("per_off_irq", 32'(timer_interrupt), 32'h0);

    // Masked expiry on ch2
    wr(PRESCALE_A, 32'd0);
    wr(ra(2, 0), 32'd3);
    wr(ra(2, 1), 32'h1);
    repeat (5) cyc();
    chk("mask_irq", 32'(timer_interrupt), 32'h0);
    rdchk("mask_status", ra(2, 2), 32'h1);
    rdchk("mask_summary", SUMMARY_A, 32'h4);
    rdchk("mask_ctrl", ra(2, 1), 32'h0);
    wr(ra(2, 1), 32'h4);
    chk("unmask_irq", 32'(timer_interrupt), 32'h4);
    wr(ra(2, 2), 32'h0);
    chk("w0_no_clear", 32'(timer_interrupt), 32'h4);
    wr(ra(2, 2), 32'h1);
    chk("mask_clr_irq", 32'(timer_interrupt), 32'h0);

    // COUNT write on ch0 expiry cycle
    wr(ra(0, 0), 32'd3);
    wr(ra(0, 1), 32'h7);
    cyc();
    cyc();
    wr(ra(0, 0), 32'd9);
    rdchk("col_count", ra(0, 0), 32'd9);
    rdchk("col_pending", ra(0, 2), 32'h0);
    chk("col_irq0", 32'(timer_interrupt[0]), 32'h0);
    wr(ra(0, 1), 32'h0);

    // W1C on ch1 expiry cycle
    wr(ra(1, 0), 32'd2);
    wr(ra(1, 1), 32'h7);
    cyc();
    wr(ra(1, 2), 32'h1);
    chk("w1c_col_irq", 32'(timer_interrupt[1]), 32'h1);
    rdchk("w1c_col_status", ra(1, 2), 32'h1);
    wr(ra(1, 1), 32'h0);
    wr(ra(1, 2), 32'h1);
    chk("w1c_col_off", 32'(timer_interrupt), 32'h0);

    // Width truncation and unmapped addresses
    wr(ra(3, 0), 32'h1FF);
    rdchk("trunc_count", ra(3, 0), 32'hFF);
    wr(ra(3, 1), 32'hFFFF_FFF8);
    rdchk("ctrl_hibits", ra(3, 1), 32'h0);
    rdchk("unmap_rd", UNMAP_A, 32'h0);
    rdchk("chan_reg3_rd", ra(0, 3), 32'h0);
    wr(UNMAP_A, 32'hFFFF_FFFF);
    rdchk("unmap_prescale", PRESCALE_A, 32'h0);
    rdchk("unmap_count3", ra(3, 0), 32'hFF);
    rdchk("unmap_ctrl3", ra(3, 1), 32'h0);
    rdchk("unmap_summary", SUMMARY_A, 32'h0);
    rdchk("unmap_rd2", UNMAP_A, 32'h0);

    // Reset mid-operation
    wr(ra(0, 0), 32'd50);
    wr(ra(0, 1), 32'h7);
    wr(ra(1, 0), 32'd60);
    wr(ra(1, 1), 32'h7);
    wr(ra(2, 0), 32'd70);
    wr(ra(2, 1), 32'h5);
    wr(ra(3, 0), 32'd1);
    wr(ra(3, 1), 32'h5);
    repeat (3) cyc();
    chk("pre_rst_irq", 32'(timer_interrupt), 32'h8);
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    chk("mid_rst_irq", 32'(timer_interrupt), 32'h0);
    chk("mid_rst_rdata", bus.read_data, 32'h0);
    for (int ch = 0; ch < 4; ch++) begin
      for (int r = 0; r < 3; r++) begin
        rdchk("mid_rst_reg", ra(ch, r), 32'h0);
      end
    end
    rdchk("mid_rst_prescale", PRESCALE_A, 32'h0);
    rdchk("mid_rst_summary", SUMMARY_A, 32'h0);
    any_irq = 1'b0;
    repeat (200) begin
      cyc();
      any_irq = any_irq | (|timer_interrupt);
    end
    chk("post_rst_quiet", 32'(any_irq), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
